// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: shared types and sizing helpers for the power-enable sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pwr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAMP   = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } pwr_seq_state_t;

    // Width needed to hold a step index 0..num_modules inclusive.
    function automatic int step_w(input int num_modules);
        return $clog2(num_modules + 1);
    endfunction

    // Largest value a cnt_w-bit saturating counter may hold.
    function automatic longint unsigned sat_max(input int cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/pwr_en_sequencer_if.sv
// pwr_en_sequencer_if: per-step report channel (valid/ready) from the sequencer to its consumer.
// Latency: n/a (wires only).
// Backpressure: producer holds the record stable while rpt_valid && !rpt_ready.
interface pwr_en_sequencer_if
    import pwr_seq_pkg::*;
#(
    parameter int NUM_MODULES = 32,
    parameter int CNT_W       = 16
);
    localparam int STEP_W = step_w(NUM_MODULES);

    logic              rpt_valid;
    logic              rpt_ready;
    logic [STEP_W-1:0] rpt_step;
    logic [CNT_W-1:0]  rpt_toggles;

    modport master (
        output rpt_valid,
        output rpt_step,
        output rpt_toggles,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_step,
        input  rpt_toggles,
        output rpt_ready
    );
endinterface

// File: rtl/popcount_sat.sv
// popcount_sat: adds the number of set bits in vec to acc, clamping at the CNT_W all-ones value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module popcount_sat
    import pwr_seq_pkg::*;
#(
    parameter int NUM_MODULES = 32,
    parameter int CNT_W       = 16
) (
    input  logic [NUM_MODULES-1:0] vec,
    input  logic [CNT_W-1:0]       acc,
    output logic [CNT_W-1:0]       sum
);
    localparam int PC_W  = $clog2(NUM_MODULES + 1);
    localparam int EXT_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(sat_max(CNT_W));

    logic [PC_W-1:0]  pc;
    logic [EXT_W-1:0] ext;

    // Count set bits, add with one spare bit of headroom, then clamp.
    always_comb begin
        pc = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            pc = pc + PC_W'(vec[i]);
        end
        ext = EXT_W'(acc) + EXT_W'(pc);
        if (ext > EXT_W'(SAT_MAX)) begin
            sum = SAT_MAX;
        end else begin
            sum = ext[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/pwr_en_sequencer.sv
// pwr_en_sequencer: staircase ramp of load-array enables (0, 1, 3, 7 ...) with one report per step.
// Latency: busy one clock after start; each step lasts dwell cycles then at least one report cycle.
// Backpressure: REPORT holds record and enables until rpt_ready; abort drops it. Option PWR_SEQ_ACTIVITY_EN.
module pwr_en_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int NUM_MODULES = 32,
    parameter int DWELL_W     = 32,
    parameter int CNT_W       = 16
) (
    input  logic                   clk100m,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DWELL_W-1:0]     dwell_cycles,
    input  logic [NUM_MODULES-1:0] dummy_in,
    output logic [NUM_MODULES-1:0] pwr_en_out,
    output logic                   busy,
    output logic                   done,
    pwr_en_sequencer_if.master     rpt
);
    localparam int STEP_W = step_w(NUM_MODULES);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_MODULES);

    pwr_seq_state_t         state;
    pwr_seq_state_t         state_nxt;
    logic [STEP_W-1:0]      step;
    logic [DWELL_W-1:0]     dwell_len;
    logic [DWELL_W-1:0]     dwell_cnt;
    logic [DWELL_W-1:0]     dwell_eff;
    logic [NUM_MODULES-1:0] next_mask;
    logic                   dwell_end;
    logic                   seq_start;
    logic                   rpt_accept;
    logic                   step_advance;

    // A zero dwell would never end a step, so it is run as a single cycle.
    assign dwell_eff    = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    assign dwell_end    = (dwell_cnt == DWELL_W'(1));
    assign seq_start    = (state == ST_IDLE) && start;
    // Abort wins over a simultaneous ready: that record is treated as undelivered.
    assign rpt_accept   = (state == ST_REPORT) && rpt.rpt_ready && !abort;
    assign step_advance = rpt_accept && (step != LAST_STEP);

    // State register.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only looked at in IDLE, abort everywhere else.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (abort)          state_nxt = ST_IDLE;
                else if (dwell_end) state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                if (abort)              state_nxt = ST_IDLE;
                else if (rpt.rpt_ready) state_nxt = (step == LAST_STEP) ? ST_DONE : ST_RAMP;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        rpt.rpt_valid = (state == ST_REPORT);
    end

    assign rpt.rpt_step = step;

    // Enable pattern for the step about to start: its lowest (step+1) modules on.
    always_comb begin
        next_mask = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            next_mask[i] = (i <= int'(step));
        end
    end

    // Step index, dwell timer and enable vector; enables change on the same edge the new step begins.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            step       <= '0;
            dwell_len  <= '0;
            dwell_cnt  <= '0;
            pwr_en_out <= '0;
        end else if (seq_start) begin
            step       <= '0;
            dwell_len  <= dwell_eff;
            dwell_cnt  <= dwell_eff;
            pwr_en_out <= '0;
        end else if (abort) begin
            pwr_en_out <= '0;
        end else if (state == ST_RAMP) begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end else if (step_advance) begin
            step       <= step + STEP_W'(1);
            pwr_en_out <= next_mask;
            dwell_cnt  <= dwell_len;
        end else if (rpt_accept) begin
            pwr_en_out <= '0;
        end
    end

`ifdef PWR_SEQ_ACTIVITY_EN
    logic [NUM_MODULES-1:0] dummy_prev;
    logic [NUM_MODULES-1:0] dummy_diff;
    logic [CNT_W-1:0]       toggles;
    logic [CNT_W-1:0]       toggles_sum;
    logic                   ramp_count;

    assign dummy_diff = dummy_in ^ dummy_prev;
    assign ramp_count = (state == ST_RAMP) && !abort;

    popcount_sat #(
        .NUM_MODULES (NUM_MODULES),
        .CNT_W       (CNT_W)
    ) u_popcount_sat (
        .vec (dummy_diff),
        .acc (toggles),
        .sum (toggles_sum)
    );

    // Previous activity sample, tracked in every state so the first ramp cycle sees a real edge.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            dummy_prev <= '0;
        end else begin
            dummy_prev <= dummy_in;
        end
    end

    // Per-step toggle accumulator; frozen outside RAMP so the report stays stable.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            toggles <= '0;
        end else if (seq_start || step_advance) begin
            toggles <= '0;
        end else if (ramp_count) begin
            toggles <= toggles_sum;
        end
    end

    assign rpt.rpt_toggles = toggles;
`else
    logic unused_dummy;
    assign unused_dummy    = ^dummy_in;
    assign rpt.rpt_toggles = '0;
`endif

endmodule
